// File: rtl/store_buffer.sv
// ============================================================================
// Module      : store_buffer
// Description : Circular store buffer between pipeline and data memory; drains
//               stores when idle, services loads with one-cycle latency.
//               Define STORE_FWD_EN to forward pending store data to loads.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [15:0] st_addr,
  input  logic [15:0] st_data,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [15:0] ld_addr,
  output logic [15:0] ld_data,
  output logic        ld_done,
  output logic [15:0] mem_access_addr,
  output logic [15:0] mem_write_data,
  output logic        mem_write_en,
  output logic        mem_read,
  input  logic [15:0] mem_read_data,
  output logic        empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [15:0]   addr_q [DEPTH];
  logic [15:0]   data_q [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   ld_data_q, ld_data_d;
  logic          ld_done_q;

  logic full, st_push, ld_acc, drain;
  logic [15:0] ld_result;

  assign full     = (count_q == FULL_CNT);
  assign st_ready = ~full;
  assign empty    = (count_q == '0);
`ifdef STORE_FWD_EN
  assign ld_ready = ~full;
`else
  assign ld_ready = (count_q == '0);
`endif
  assign st_push = st_valid & st_ready;
  assign ld_acc  = ld_valid & ld_ready;
  assign drain   = ~ld_acc & (count_q != '0);

`ifdef STORE_FWD_EN
  logic [AW-1:0] scan_idx;
  logic          fwd_hit;
  logic [15:0]   fwd_data;

  // Scan oldest to youngest so the last match wins (youngest store).
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    scan_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head_q + AW'(i);
      if ((CW'(i) < count_q) && (addr_q[scan_idx][2:0] == ld_addr[2:0])) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[scan_idx];
      end
    end
  end
  assign ld_result = fwd_hit ? fwd_data : mem_read_data;
`else
  assign ld_result = mem_read_data;
`endif

  // Memory port is forced quiet while reset is held, independent of inputs.
  always_comb begin
    mem_access_addr = '0;
    mem_write_data  = '0;
    mem_write_en    = 1'b0;
    mem_read        = 1'b0;
    if (reset_n) begin
      if (ld_acc) begin
        mem_access_addr = ld_addr;
        mem_read        = 1'b1;
      end else if (drain) begin
        mem_access_addr = addr_q[head_q];
        mem_write_data  = data_q[head_q];
        mem_write_en    = 1'b1;
      end
    end
  end

  always_comb begin
    head_d    = drain   ? head_q + 1'b1 : head_q;
    tail_d    = st_push ? tail_q + 1'b1 : tail_q;
    ld_data_d = ld_acc  ? ld_result     : ld_data_q;
    case ({st_push, drain})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      ld_data_q <= '0;
      ld_done_q <= 1'b0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      ld_data_q <= ld_data_d;
      ld_done_q <= ld_acc;
    end
  end

  always_ff @(posedge clk) begin
    if (st_push) begin
      addr_q[tail_q] <= st_addr;
      data_q[tail_q] <= st_data;
    end
  end

  assign ld_data = ld_data_q;
  assign ld_done = ld_done_q;

endmodule

`default_nettype wire

// File: tb/tb_store_buffer.sv
// ============================================================================
// Module      : tb_store_buffer
// Description : Self-checking bench for store_buffer against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        st_valid, st_ready, ld_valid, ld_ready, ld_done;
  logic [15:0] st_addr, st_data, ld_addr, ld_data;
  logic [15:0] mem_access_addr, mem_write_data, mem_read_data;
  logic        mem_write_en, mem_read, empty;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
    .ld_data(ld_data), .ld_done(ld_done),
    .mem_access_addr(mem_access_addr), .mem_write_data(mem_write_data),
    .mem_write_en(mem_write_en), .mem_read(mem_read),
    .mem_read_data(mem_read_data), .empty(empty)
  );

  always #5 clk = ~clk;

  // Data memory: eight words decoded on address bits [2:0].
  logic [15:0] tb_mem [8];
  assign mem_read_data = tb_mem[mem_access_addr[2:0]];
  always @(posedge clk) if (mem_write_en) tb_mem[mem_access_addr[2:0]] <= mem_write_data;

  typedef struct packed { logic [15:0] a; logic [15:0] d; } ent_t;
  ent_t        q[$];
  logic [15:0] ref_mem [8];
  logic [15:0] exp_ld_data;
  logic        exp_ld_done;
  int          n_total = 0;
  int          n_bad   = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive, check against the model, advance the model.
  task automatic cycle(input logic sv, input logic [15:0] sa, input logic [15:0] sd,
                       input logic lv, input logic [15:0] la);
    int          cnt;
    logic        e_st_rdy, e_ld_rdy, acc, drn, found;
    logic [15:0] res;
    st_valid = sv; st_addr = sa; st_data = sd;
    ld_valid = lv; ld_addr = la;
    #1;
    cnt      = q.size();
    e_st_rdy = (cnt < DEPTH);
`ifdef STORE_FWD_EN
    e_ld_rdy = (cnt < DEPTH);
`else
    e_ld_rdy = (cnt == 0);
`endif
    acc = lv && e_ld_rdy;
    drn = !acc && cnt > 0;
    chk("st_ready", {15'd0, st_ready}, {15'd0, e_st_rdy});
    chk("ld_ready", {15'd0, ld_ready}, {15'd0, e_ld_rdy});
    chk("empty",    {15'd0, empty},    {15'd0, cnt == 0});
    chk("ld_data",  ld_data, exp_ld_data);
    chk("ld_done",  {15'd0, ld_done},  {15'd0, exp_ld_done});
    chk("mem_read", {15'd0, mem_read}, {15'd0, acc});
    chk("mem_we",   {15'd0, mem_write_en}, {15'd0, drn});
    if (acc)      chk("ld_addr_out", mem_access_addr, la);
    else if (drn) chk("drain_addr", mem_access_addr, q[0].a);
    else          chk("idle_addr", mem_access_addr, 16'h0);
    if (drn)       chk("drain_data", mem_write_data, q[0].d);
    else if (!acc) chk("idle_wdata", mem_write_data, 16'h0);
    res   = ref_mem[la[2:0]];
    found = 1'b0;
`ifdef STORE_FWD_EN
    for (int i = cnt - 1; i >= 0; i--)
      if (!found && q[i].a[2:0] == la[2:0]) begin
        res   = q[i].d;
        found = 1'b1;
      end
`endif
    @(posedge clk);
    if (drn) begin
      ref_mem[q[0].a[2:0]] = q[0].d;
      void'(q.pop_front());
    end
    if (sv && e_st_rdy) q.push_back('{a: sa, d: sd});
    if (acc) exp_ld_data = res;
    exp_ld_done = acc;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
  endtask

  task automatic reset_check(input string tag);
    st_valid = 1'b1; ld_valid = 1'b1; ld_addr = 16'h0003; st_addr = 16'h0004;
    reset_n = 1'b0;
    #1;
    chk({tag, "_mem_read"}, {15'd0, mem_read}, 16'h0);
    chk({tag, "_mem_we"},   {15'd0, mem_write_en}, 16'h0);
    chk({tag, "_mem_addr"}, mem_access_addr, 16'h0);
    chk({tag, "_mem_wdata"}, mem_write_data, 16'h0);
    chk({tag, "_ld_data"},  ld_data, 16'h0);
    chk({tag, "_ld_done"},  {15'd0, ld_done}, 16'h0);
    chk({tag, "_empty"},    {15'd0, empty}, 16'h1);
    q.delete();
    exp_ld_data = '0;
    exp_ld_done = 1'b0;
    @(posedge clk);
    @(negedge clk);
    st_valid = 1'b0; ld_valid = 1'b0;
    reset_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      tb_mem[i]  = 16'($urandom);
      ref_mem[i] = tb_mem[i];
    end
    st_valid = 0; ld_valid = 0; st_addr = 0; st_data = 0; ld_addr = 0;
    @(negedge clk);
    reset_check("rst0");

    // Single store then drain.
    cycle(1'b1, 16'h0003, 16'hA5A5, 1'b0, 16'h0);
    idle(2);

    // Stores pushed back-to-back while a load is held pending.
    for (int i = 0; i < 7; i++) cycle(1'b1, 16'(16 + i), 16'(16'h5000 + i), 1'b1, 16'h0007);
    idle(DEPTH + 1);

    // Two stores to the same word, then a load aliasing on bits [2:0].
    cycle(1'b1, 16'h0005, 16'h1111, 1'b0, 16'h0);
    cycle(1'b1, 16'h0005, 16'h2222, 1'b0, 16'h0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 16'h0, 16'h0, 1'b1, 16'hFFFD);
    idle(1);
    chk("alias_load_val", ld_data, 16'h2222);
    idle(2);

    // Same-cycle store and load: the load sees the older memory value.
    tb_mem[2]  = 16'h0001;
    ref_mem[2] = 16'h0001;
    cycle(1'b1, 16'h0002, 16'hBEEF, 1'b1, 16'h0002);
    idle(1);
    chk("same_cycle_load", ld_data, 16'h0001);
    idle(2);

    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      cycle(($urandom % 10) < 6, 16'($urandom), 16'($urandom),
            ($urandom % 10) < 4, 16'($urandom));

    // Reset with pending stores; none of them may reach memory afterwards.
    idle(DEPTH + 1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 16'(i + 1), 16'hDEAD, 1'b0, 16'h0);
    reset_check("rst1");
    idle(4);
    for (int i = 1; i < 4; i++) chk("no_discard_write", tb_mem[i], ref_mem[i]);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
